leg_fetch_decode: RTL and testbench
===================================

Name: leg_fetch_decode

Overview:
Upstream stage of the 8-bit LEG ALU.
- Fetches each 4-byte LEG instruction (opcode, arg1, arg2, dest) over a byte-wide program-memory port.
- Resolves immediate flags and register reads.
- Presents the ALU opcode, both operands and the destination to the execute stage through a valid/ready handshake.
- Owns the program counter, including redirect from the downstream branch/condition logic.

Parameters:
DATA_W, 8, operand/instruction byte width
PC_W, 8, program counter width; arithmetic mod 2^PC_W
REG_COUNT, 6, number of general registers (indices 0..REG_COUNT-1)

Ports:
clk  input  1  clock
rst  input  1  reset
pm_req  output  1  program-memory byte request
pm_addr  output  PC_W  byte address requested
pm_data  input  DATA_W  returned byte
pm_valid  input  1  pm_data valid for current pm_addr
rf_raddr_a  output  3  register-file read address, operand 1
rf_raddr_b  output  3  register-file read address, operand 2
rf_rdata_a  input  DATA_W  async read data, operand 1
rf_rdata_b  input  DATA_W  async read data, operand 2
alu_opcode  output  8  opcode with immediate flags cleared
alu_in1  output  DATA_W  operand 1 (ALU Input_1)
alu_in2  output  DATA_W  operand 2 (ALU Input_2)
dest  output  8  destination byte, passed through
out_valid  output  1  issue bundle valid
out_ready  input  1  execute stage accepts bundle
branch_taken  input  1  redirect request, sampled on handshake
branch_target  input  PC_W  redirect address
pc  output  PC_W  address of current instruction

Interface rule: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, rst=1):
  - State F0; pc=0; instruction bytes=0.
  - alu_opcode, alu_in1, alu_in2, dest = 0.
  - out_valid=0, pm_req=0.
- FSM states: F0, F1, F2, F3, DEC, ISSUE.
- F0..F3:
  - pm_req=1, pm_addr = pc+i (i=0..3, wraps mod 2^PC_W).
  - On pm_valid, latch pm_data into byte i and advance.
  - Without pm_valid, hold state and address; no timeout.
- F3 with pm_valid -> DEC; pm_req=0 in DEC and ISSUE.
- DEC (one cycle):
  - rf_raddr_a = arg1[2:0], rf_raddr_b = arg2[2:0].
  - Operand select for operand n:
    - If opcode bit (8-n) is set (bit7 for op1, bit6 for op2): the raw arg byte (immediate).
    - Else if arg index < REG_COUNT: rf_rdata.
    - Else if index == 6: pc of this instruction.
    - Else (index 7): 0.
  - Register into alu_in1/alu_in2; alu_opcode = {2'b00, opcode[5:0]}; dest = byte 3.
  - -> ISSUE.
- ISSUE:
  - out_valid=1; all outputs held stable until out_valid && out_ready.
  - On handshake: pc <= branch_taken ? branch_target : pc+4 (wrap, e.g. 0xFC -> 0x00); out_valid=0 next cycle; -> F0.
- branch_taken outside the handshake cycle is ignored.
- Minimum throughput: 6 cycles per instruction (4 fetch + DEC + ISSUE with out_ready=1).
- rf_raddr_* outside DEC: hold last value (don't-care to downstream).
- Reset asserted mid-fetch or mid-ISSUE: immediate return to reset values; pending bundle dropped.

Optional Feature:
LEG_FD_STALL_COUNT_EN
- Defined: adds output stall_cnt (16 bits), reset 0. Increments each cycle either
  - in ISSUE with out_ready=0, or
  - in F0..F3 with pm_valid=0.
  Saturates at 0xFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package leg_pkg:
  - FSM state enum.
  - INSTR_BYTES=4, IMM1_BIT=7, IMM2_BIT=6, OPC_MASK=8'h3F, REG_PC_IDX=6, REG_ZERO_IDX=7.
- Sub-module leg_operand_select: one operand mux (imm flag, arg byte, rf data, pc -> operand); instantiated twice.

Test Plan:
- Reset then program bytes 00 01 02 03, regs r1=5 r2=3, out_ready=1:
  - Bundle opcode=00, in1=5, in2=3, dest=03.
  - out_valid rises on cycle 6 after fetch start; next pm_addr=04.
- Opcode C1 (both imm, SUB), args 0A 04:
  - alu_opcode=01, in1=0A, in2=04 (registers not used).
- pm_valid withheld 3 cycles on byte 2:
  - pm_addr holds pc+2; no byte skipped; bundle correct.
  - With LEG_FD_STALL_COUNT_EN defined: stall_cnt=3.
- out_ready low 5 cycles in ISSUE:
  - All outputs stable; pc unchanged.
  - Handshake with branch_taken=1, branch_target=0x40: next pm_addr=0x40.
- pc=0xFC, handshake without branch:
  - pc wraps to 0x00.
  - Arg index 6 non-immediate on instruction at 0xFC: operand = 0xFC.
  - Arg index 7: operand = 0x00.
- rst pulsed while in F2:
  - pc=0, out_valid=0, pm_req=0 immediately.
  - Fetch restarts at address 0.

Source files
------------

// File: rtl/leg_pkg.sv
// Shared types and constants for the LEG fetch/decode stage.
package leg_pkg;

   typedef enum logic [2:0] {
      StF0,
      StF1,
      StF2,
      StF3,
      StDec,
      StIssue
   } fd_state_e;

   localparam int unsigned INSTR_BYTES  = 4;
   localparam int unsigned IMM1_BIT     = 7;
   localparam int unsigned IMM2_BIT     = 6;
   localparam logic [7:0]  OPC_MASK     = 8'h3F;
   localparam logic [2:0]  REG_PC_IDX   = 3'd6;
   localparam logic [2:0]  REG_ZERO_IDX = 3'd7;

endpackage

// File: rtl/leg_fetch_decode_if.sv
// Issue bundle from fetch/decode to execute, plus the branch redirect path back.
interface leg_fetch_decode_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned PC_W   = 8
);

   logic [7:0]        alu_opcode;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic [7:0]        dest;
   logic              out_valid;
   logic              out_ready;
   logic              branch_taken;
   logic [PC_W-1:0]   branch_target;

   modport master (
      output alu_opcode, alu_in1, alu_in2, dest, out_valid,
      input  out_ready, branch_taken, branch_target
   );

   modport slave (
      input  alu_opcode, alu_in1, alu_in2, dest, out_valid,
      output out_ready, branch_taken, branch_target
   );

endinterface

// File: rtl/leg_operand_select.sv
// One ALU operand mux: immediate byte, register read, pc, or zero.
module leg_operand_select
   import leg_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PC_W      = 8,
   parameter int unsigned REG_COUNT = 6
) (
   input  logic              imm,
   input  logic [DATA_W-1:0] arg,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] operand
);

   logic [2:0] idx;

   assign idx = arg[2:0];

   always_comb begin
      operand = '0;
      if (imm) begin
         operand = arg;
      end else if (32'(idx) < REG_COUNT) begin
         operand = rf_data;
      end else if (idx == REG_PC_IDX) begin
         operand = DATA_W'(pc);
      end else if (idx == REG_ZERO_IDX) begin
         operand = '0;
      end
   end

endmodule

// File: rtl/leg_fetch_decode.sv
// LEG fetch/decode: byte-serial instruction fetch, operand resolve, valid/ready issue.
// Optional LEG_FD_STALL_COUNT_EN adds a saturating 16-bit stall_cnt output.
module leg_fetch_decode
   import leg_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PC_W      = 8,
   parameter int unsigned REG_COUNT = 6
) (
   input  logic              clk,
   input  logic              rst,
   output logic              pm_req,
   output logic [PC_W-1:0]   pm_addr,
   input  logic [DATA_W-1:0] pm_data,
   input  logic              pm_valid,
   output logic [2:0]        rf_raddr_a,
   output logic [2:0]        rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   leg_fetch_decode_if.master issue,
   output logic [PC_W-1:0]   pc
`ifdef LEG_FD_STALL_COUNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   fd_state_e         state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] instr_q [INSTR_BYTES];
   logic [7:0]        opcode_q, dest_q;
   logic [DATA_W-1:0] in1_q, in2_q;
   logic [2:0]        raddr_a_q, raddr_b_q;

   logic              fetching;
   logic [1:0]        fetch_idx;
   logic              latch_byte;
   logic              load_bundle;
   logic [DATA_W-1:0] operand_a, operand_b;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fetching    = 1'b0;
      fetch_idx   = 2'd0;
      latch_byte  = 1'b0;
      load_bundle = 1'b0;
      unique case (state_q)
         StF0: begin
            fetching = 1'b1;
            fetch_idx = 2'd0;
            if (pm_valid) begin
               latch_byte = 1'b1;
               state_d = StF1;
            end
         end
         StF1: begin
            fetching = 1'b1;
            fetch_idx = 2'd1;
            if (pm_valid) begin
               latch_byte = 1'b1;
               state_d = StF2;
            end
         end
         StF2: begin
            fetching = 1'b1;
            fetch_idx = 2'd2;
            if (pm_valid) begin
               latch_byte = 1'b1;
               state_d = StF3;
            end
         end
         StF3: begin
            fetching = 1'b1;
            fetch_idx = 2'd3;
            if (pm_valid) begin
               latch_byte = 1'b1;
               state_d = StDec;
            end
         end
         StDec: begin
            load_bundle = 1'b1;
            state_d = StIssue;
         end
         StIssue: begin
            if (issue.out_ready) begin
               pc_d = issue.branch_taken ? issue.branch_target : pc_q + PC_W'(INSTR_BYTES);
               state_d = StF0;
            end
         end
         default: state_d = StF0;
      endcase
   end

   // Register reads are async, so the address must be live in DEC itself.
   assign rf_raddr_a = (state_q == StDec) ? instr_q[1][2:0] : raddr_a_q;
   assign rf_raddr_b = (state_q == StDec) ? instr_q[2][2:0] : raddr_b_q;

   leg_operand_select #(
      .DATA_W   (DATA_W),
      .PC_W     (PC_W),
      .REG_COUNT(REG_COUNT)
   ) u_sel_a (
      .imm    (instr_q[0][IMM1_BIT]),
      .arg    (instr_q[1]),
      .rf_data(rf_rdata_a),
      .pc     (pc_q),
      .operand(operand_a)
   );

   leg_operand_select #(
      .DATA_W   (DATA_W),
      .PC_W     (PC_W),
      .REG_COUNT(REG_COUNT)
   ) u_sel_b (
      .imm    (instr_q[0][IMM2_BIT]),
      .arg    (instr_q[2]),
      .rf_data(rf_rdata_b),
      .pc     (pc_q),
      .operand(operand_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StF0;
         pc_q      <= '0;
         for (int i = 0; i < INSTR_BYTES; i++) begin
            instr_q[i] <= '0;
         end
         opcode_q  <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         dest_q    <= '0;
         raddr_a_q <= '0;
         raddr_b_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (latch_byte) begin
            instr_q[fetch_idx] <= pm_data;
         end
         if (load_bundle) begin
            opcode_q  <= instr_q[0][7:0] & OPC_MASK;
            in1_q     <= operand_a;
            in2_q     <= operand_b;
            dest_q    <= instr_q[3][7:0];
            raddr_a_q <= instr_q[1][2:0];
            raddr_b_q <= instr_q[2][2:0];
         end
      end
   end

   // Reset must read as no request even though the state already sits in F0.
   assign pm_req           = fetching & ~rst;
   assign pm_addr          = pc_q + PC_W'(fetch_idx);
   assign pc               = pc_q;
   assign issue.out_valid  = (state_q == StIssue);
   assign issue.alu_opcode = opcode_q;
   assign issue.alu_in1    = in1_q;
   assign issue.alu_in2    = in2_q;
   assign issue.dest       = dest_q;

`ifdef LEG_FD_STALL_COUNT_EN
   logic [15:0] stall_q;
   logic        stall_ev;

   assign stall_ev = ((state_q == StIssue) & ~issue.out_ready) | (fetching & ~pm_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (stall_ev && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_leg_fetch_decode.sv
// Self-checking bench for leg_fetch_decode: directed cases plus randomized traffic vs a model.
module tb_leg_fetch_decode;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pm_req;
   logic [7:0] pm_addr;
   logic [7:0] pm_data;
   logic       pm_valid;
   logic [2:0] rf_raddr_a, rf_raddr_b;
   logic [7:0] rf_rdata_a, rf_rdata_b;
   logic [7:0] pc;
`ifdef LEG_FD_STALL_COUNT_EN
   logic [15:0] stall_cnt;
`endif

   logic [7:0] mem  [256];
   logic [7:0] regs [8];
   logic [7:0] junk;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   leg_fetch_decode_if #(.DATA_W(8), .PC_W(8)) issue ();

   assign pm_data    = pm_valid ? mem[pm_addr] : junk;
   assign rf_rdata_a = regs[rf_raddr_a];
   assign rf_rdata_b = regs[rf_raddr_b];

   leg_fetch_decode #(
      .DATA_W   (8),
      .PC_W     (8),
      .REG_COUNT(6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pm_req    (pm_req),
      .pm_addr   (pm_addr),
      .pm_data   (pm_data),
      .pm_valid  (pm_valid),
      .rf_raddr_a(rf_raddr_a),
      .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a),
      .rf_rdata_b(rf_rdata_b),
      .issue     (issue),
      .pc        (pc)
`ifdef LEG_FD_STALL_COUNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: transaction-level view of the stage.
   logic [7:0] m_pc;
   int         m_k;
   bit         m_dec;
   logic [7:0] e_op, e_in1, e_in2, e_dest;
   int         m_stall;
   logic [7:0] b0, b1, b2, b3;

   function automatic logic [7:0] m_operand(input bit imm, input logic [7:0] arg,
                                            input logic [7:0] pcv);
      if (imm) return arg;
      if (arg[2:0] < 3'd6) return regs[arg[2:0]];
      if (arg[2:0] == 3'd6) return pcv;
      return 8'h00;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         m_pc = 8'h00;
         m_k = 0;
         m_dec = 0;
         e_op = 0; e_in1 = 0; e_in2 = 0; e_dest = 0;
         m_stall = 0;
         chk("rst_pm_req", {31'd0, pm_req}, 0);
         chk("rst_out_valid", {31'd0, issue.out_valid}, 0);
         chk("rst_pc", {24'd0, pc}, 0);
         chk("rst_bundle", {issue.alu_opcode, issue.alu_in1, issue.alu_in2, issue.dest}, 0);
      end else begin
         chk("m_pm_req", {31'd0, pm_req}, {31'd0, (m_k < 4)});
         chk("m_out_valid", {31'd0, issue.out_valid}, {31'd0, (m_k == 4 && m_dec)});
         chk("m_pc", {24'd0, pc}, {24'd0, m_pc});
         if (m_k < 4) chk("m_pm_addr", {24'd0, pm_addr}, {24'd0, m_pc + 8'(m_k)});
         chk("m_bundle", {issue.alu_opcode, issue.alu_in1, issue.alu_in2, issue.dest},
             {e_op, e_in1, e_in2, e_dest});
`ifdef LEG_FD_STALL_COUNT_EN
         chk("m_stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
`endif
         if (m_k < 4) begin
            if (pm_valid) m_k++;
            else if (m_stall < 65535) m_stall++;
         end else if (!m_dec) begin
            b0 = mem[m_pc];
            b1 = mem[m_pc + 8'd1];
            b2 = mem[m_pc + 8'd2];
            b3 = mem[m_pc + 8'd3];
            chk("m_rf_raddr", {26'd0, rf_raddr_a, rf_raddr_b}, {26'd0, b1[2:0], b2[2:0]});
            m_dec  = 1;
            e_op   = {2'b00, b0[5:0]};
            e_in1  = m_operand(b0[7], b1, m_pc);
            e_in2  = m_operand(b0[6], b2, m_pc);
            e_dest = b3;
         end else if (issue.out_ready) begin
            m_pc  = issue.branch_taken ? issue.branch_target : m_pc + 8'd4;
            m_k   = 0;
            m_dec = 0;
         end else if (m_stall < 65535) begin
            m_stall++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      junk = 8'($urandom);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!issue.out_valid && n < 60) begin
         step();
         n++;
      end
      chk(nm, {31'd0, issue.out_valid}, 1);
   endtask

   task automatic wait_addr(input string nm, input logic [7:0] a);
      int n = 0;
      while (!(pm_req && pm_addr == a) && n < 60) begin
         step();
         n++;
      end
      chk(nm, {24'd0, pm_addr}, {24'd0, a});
   endtask

   int lat;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      regs[1] = 8'h05;
      regs[2] = 8'h03;
      regs[4] = 8'h99;
      mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
      mem[4] = 8'hC1; mem[5] = 8'h0A; mem[6] = 8'h04; mem[7] = 8'h07;
      mem[8] = 8'h02; mem[9] = 8'h01; mem[10] = 8'h02; mem[11] = 8'h05;
      mem[8'hFC] = 8'h00; mem[8'hFD] = 8'h06; mem[8'hFE] = 8'h07; mem[8'hFF] = 8'h09;
      junk = 8'hA5;
      pm_valid = 1'b1;
      issue.out_ready = 1'b1;
      issue.branch_taken = 1'b0;
      issue.branch_target = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic register-operand instruction and issue latency.
      lat = 0;
      while (!issue.out_valid && lat < 60) begin
         step();
         lat++;
      end
      chk("t1_latency", 32'(lat), 5);
      chk("t1_opcode", {24'd0, issue.alu_opcode}, 32'h00);
      chk("t1_in1", {24'd0, issue.alu_in1}, 32'h05);
      chk("t1_in2", {24'd0, issue.alu_in2}, 32'h03);
      chk("t1_dest", {24'd0, issue.dest}, 32'h03);
      step();
      chk("t1_next_addr", {23'd0, pm_req, pm_addr}, {23'd0, 1'b1, 8'h04});

      // Both immediates.
      wait_valid("t2_valid");
      chk("t2_opcode", {24'd0, issue.alu_opcode}, 32'h01);
      chk("t2_in1", {24'd0, issue.alu_in1}, 32'h0A);
      chk("t2_in2", {24'd0, issue.alu_in2}, 32'h04);
      step();
      chk("t2_pc", {24'd0, pc}, 32'h08);

      // Memory stall on byte 2, then execute back-pressure and branch.
      issue.out_ready = 1'b0;
      wait_addr("t3_reach_f2", 8'h0A);
      pm_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_addr_hold", {23'd0, pm_req, pm_addr}, {23'd0, 1'b1, 8'h0A});
      end
      pm_valid = 1'b1;
      wait_valid("t3_valid");
      chk("t3_bundle", {issue.alu_opcode, issue.alu_in1, issue.alu_in2, issue.dest},
          32'h02050305);
`ifdef LEG_FD_STALL_COUNT_EN
      chk("t3_stall_cnt", {16'd0, stall_cnt}, 3);
`endif
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_hold_bundle", {issue.alu_opcode, issue.alu_in1, issue.alu_in2, issue.dest},
             32'h02050305);
         chk("t4_hold_pc", {23'd0, issue.out_valid, pc}, {23'd0, 1'b1, 8'h08});
      end
`ifdef LEG_FD_STALL_COUNT_EN
      chk("t4_stall_cnt", {16'd0, stall_cnt}, 8);
`endif
      issue.out_ready = 1'b1;
      issue.branch_taken = 1'b1;
      issue.branch_target = 8'h40;
      step();
      issue.branch_taken = 1'b0;
      chk("t4_branch_addr", {24'd0, pm_addr}, 32'h40);

      // Branch to 0xFC (held high through fetch, only the handshake counts).
      issue.branch_taken = 1'b1;
      issue.branch_target = 8'hFC;
      wait_valid("t5_valid_a");
      step();
      issue.branch_taken = 1'b0;
      chk("t5_pc_fc", {24'd0, pc}, 32'hFC);
      wait_valid("t5_valid_b");
      chk("t5_bundle", {issue.alu_opcode, issue.alu_in1, issue.alu_in2, issue.dest},
          32'h00FC0009);
      step();
      chk("t5_wrap", {24'd0, pc}, 32'h00);
      chk("t5_wrap_addr", {24'd0, pm_addr}, 32'h00);

      // Reset mid-fetch.
      issue.branch_taken = 1'b1;
      issue.branch_target = 8'h80;
      wait_valid("t6_valid");
      step();
      issue.branch_taken = 1'b0;
      chk("t6_pc_80", {24'd0, pc}, 32'h80);
      wait_addr("t6_reach_f2", 8'h82);
      rst = 1'b1;
      #1;
      chk("t6_rst_now", {22'd0, pm_req, issue.out_valid, pc}, 0);
      step();
      rst = 1'b0;
      #1;
      chk("t6_restart", {23'd0, pm_req, pm_addr}, {23'd0, 1'b1, 8'h00});

      // Randomized traffic against the model.
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      for (int c = 0; c < 4000; c++) begin
         step();
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
         end
         pm_valid = ($urandom_range(0, 3) != 0);
         issue.out_ready = $urandom_range(0, 1) == 1;
         issue.branch_taken = ($urandom_range(0, 3) == 0);
         issue.branch_target = 8'($urandom);
         if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 8'($urandom);
      end
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
